remote_comm: RTL and testbench
==============================

Name: remote_comm

Overview:
- Host-side UART command master that emulates the remote controller of the quadcopter flight controller.
- On a request it serializes a 3-byte command frame (command byte plus 16-bit data) onto TX.
- It also receives the single-byte response (e.g. ACK 0xA5) the flight controller returns on RX.
- Used by system benches to drive SET_PTCH (0x02), SET_ROLL (0x03), SET_YAW (0x04), SET_THRST (0x05), CALIBRATE (0x06), EMER_LAND (0x07) and MTRS_OFF (0x08).

Parameters:
BAUD_DIV, 2604, clocks per UART bit (50 MHz clk, 19200 baud)

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  reset, synchronous active-low
RX  input  1  serial in from flight controller TX; asynchronous
TX  output  1  serial out to flight controller RX; idle high
cmd  input  8  command byte to send
data  input  16  data word sent with cmd
send_cmd  input  1  one-cycle pulse starts a frame
cmd_sent  output  1  high once the full 3-byte frame has been transmitted
resp_rdy  output  1  high when a response byte is valid in resp
resp  output  8  last received response byte
clr_resp_rdy  input  1  pulse clears resp_rdy

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset values:
  - TX=1, cmd_sent=0, resp_rdy=0, resp=0x00.
  - Both FSMs go to IDLE and all counters clear.
  - A reset mid-frame aborts immediately; TX is high on the cycle after reset is sampled.
- Frame format:
  - UART 8N1, LSB first, each bit held exactly BAUD_DIV clocks.
  - Byte order: cmd, then data[15:8], then data[7:0].
  - Bytes go back-to-back with no idle gap; a frame is 30 bit times.
- Transmit FSM:
  - States IDLE -> HIGH -> MID -> LOW -> IDLE. Each state sends one byte: start bit 0, 8 data bits, stop bit 1.
  - send_cmd in IDLE latches cmd and data into holding registers and clears cmd_sent.
  - TX drops to 0 (start bit) on the clock after send_cmd.
  - Later changes on cmd/data do not affect a frame in flight.
  - cmd_sent rises on the clock the final stop bit completes and stays high until the next accepted send_cmd.
  - send_cmd while not IDLE is ignored.
- Receiver:
  - RX passes through a 2-flop synchronizer; the synchronized value is 1 out of reset.
  - A falling edge in idle starts reception.
  - Sampling points: start bit at BAUD_DIV/2, each data bit every BAUD_DIV thereafter, stop bit likewise.
  - If the start-bit sample reads 1, the edge is a glitch: return to idle without asserting resp_rdy.
  - After the stop-bit sample: resp is loaded and resp_rdy is set in the same cycle.
  - Stop-bit value is not checked; no framing-error output.
- resp_rdy clearing:
  - Cleared by clr_resp_rdy or by detection of a new start bit.
  - If clr_resp_rdy and the set event land in the same cycle, the set wins.
- resp holds its value until the next completed byte.
- TX and RX paths are fully independent and may run simultaneously.

Test Plan:
- Thrust frame: after reset, send_cmd with cmd=0x05, data=0x00FF.
  - TX carries 0x05, 0x00, 0xFF LSB-first, each bit 2604 clocks.
  - cmd_sent rises 78120 clocks after TX first falls and then stays high.
- Roll frame with negative data: cmd=0x03, data=0xFF80.
  - Bytes observed are 0x03, 0xFF, 0x80.
  - cmd_sent drops the cycle after send_cmd and returns high at frame end.
- Response receive: drive RX with 0xA5 at 19200 baud.
  - resp=0xA5 and resp_rdy=1 at mid stop bit.
  - clr_resp_rdy pulse clears resp_rdy; resp stays 0xA5.
- Busy and latching: second send_cmd (cmd=0x04, data=0x0080) during the first frame, with cmd/data changed mid-frame.
  - Frame is unchanged and no second frame is sent.
  - After cmd_sent, a new send_cmd sends 0x04, 0x00, 0x80.
- Glitch rejection: a 100-clock low pulse on RX leaves resp_rdy=0 and resp unchanged.
- Reset mid-frame: assert rst_n low during the data[15:8] byte.
  - Next cycle: TX=1, cmd_sent=0, resp_rdy=0.
  - A subsequent send_cmd produces a complete correct frame.

Source files
------------

// File: rtl/remote_comm.sv
// remote_comm: host-side UART command master.
// Sends a 3-byte frame (cmd, data[15:8], data[7:0]) as 8N1 on TX and
// receives single-byte responses on RX. The TX and RX paths are independent.
module remote_comm #(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   input  logic        send_cmd,
   output logic        cmd_sent,
   output logic        resp_rdy,
   output logic [7:0]  resp,
   input  logic        clr_resp_rdy
);

   localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned BIT_W = 4;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(9);

   typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_MID, TX_LOW} tx_state_t;
   typedef enum logic       {RX_IDLE, RX_BUSY} rx_state_t;

   // ---------------------------------------------------------------- TX path
   tx_state_t        tx_state, tx_state_nxt;
   logic [7:0]       cmd_hold;
   logic [15:0]      data_hold;
   logic [8:0]       tx_shift;
   logic [CNT_W-1:0] tx_baud_cnt;
   logic [BIT_W-1:0] tx_bit_cnt;
   logic             tx_baud_end, tx_byte_end;
   logic             tx_accept, tx_load, tx_done;
   logic [7:0]       tx_byte;

   assign tx_baud_end = (tx_baud_cnt == BAUD_LAST);
   assign tx_byte_end = tx_baud_end && (tx_bit_cnt == LAST_BIT);

   // Transmit state register
   always_ff @(posedge clk) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_state_nxt;
   end

   // Transmit next state: pick the next byte to load at each byte boundary
   always_comb begin
      tx_state_nxt = tx_state;
      tx_accept    = 1'b0;
      tx_load      = 1'b0;
      tx_done      = 1'b0;
      tx_byte      = cmd;
      case (tx_state)
         TX_IDLE: if (send_cmd) begin
            tx_state_nxt = TX_HIGH;
            tx_accept    = 1'b1;
            tx_load      = 1'b1;
            tx_byte      = cmd;
         end
         TX_HIGH: if (tx_byte_end) begin
            tx_state_nxt = TX_MID;
            tx_load      = 1'b1;
            tx_byte      = data_hold[15:8];
         end
         TX_MID: if (tx_byte_end) begin
            tx_state_nxt = TX_LOW;
            tx_load      = 1'b1;
            tx_byte      = data_hold[7:0];
         end
         TX_LOW: if (tx_byte_end) begin
            tx_state_nxt = TX_IDLE;
            tx_done      = 1'b1;
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // Transmit datapath: holding registers, bit shifter and baud timing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         TX          <= 1'b1;
         cmd_sent    <= 1'b0;
         cmd_hold    <= '0;
         data_hold   <= '0;
         tx_shift    <= '1;
         tx_baud_cnt <= '0;
         tx_bit_cnt  <= '0;
      end else begin
         if (tx_accept) begin
            cmd_hold  <= cmd;
            data_hold <= data;
            cmd_sent  <= 1'b0;
         end
         if (tx_load) begin
            // start bit goes out now; shifter keeps data bits plus stop bit
            TX          <= 1'b0;
            tx_shift    <= {1'b1, tx_byte};
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= '0;
         end else if (tx_done) begin
            TX          <= 1'b1;
            cmd_sent    <= 1'b1;
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= '0;
         end else if (tx_state != TX_IDLE) begin
            if (tx_baud_end) begin
               tx_baud_cnt <= '0;
               TX          <= tx_shift[0];
               tx_shift    <= {1'b1, tx_shift[8:1]};
               tx_bit_cnt  <= tx_bit_cnt + BIT_W'(1);
            end else begin
               tx_baud_cnt <= tx_baud_cnt + CNT_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------- RX path
   rx_state_t        rx_state, rx_state_nxt;
   logic             rx_ff1, rx_sync, rx_prev;
   logic [CNT_W-1:0] rx_cnt;
   logic [BIT_W-1:0] rx_bit_cnt;
   logic [7:0]       rx_shift;
   logic             rx_start, rx_sample, rx_done;

   // Two-flop synchronizer plus one delay stage for falling-edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_ff1  <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_ff1  <= RX;
         rx_sync <= rx_ff1;
         rx_prev <= rx_sync;
      end
   end

   // Receive state register
   always_ff @(posedge clk) begin
      if (!rst_n) rx_state <= RX_IDLE;
      else        rx_state <= rx_state_nxt;
   end

   // Receive next state: start on falling edge, drop glitches, finish at stop
   always_comb begin
      rx_state_nxt = rx_state;
      rx_start     = 1'b0;
      rx_sample    = 1'b0;
      rx_done      = 1'b0;
      case (rx_state)
         RX_IDLE: if (rx_prev && !rx_sync) begin
            rx_state_nxt = RX_BUSY;
            rx_start     = 1'b1;
         end
         RX_BUSY: if (rx_cnt == '0) begin
            rx_sample = 1'b1;
            if ((rx_bit_cnt == '0) && rx_sync) begin
               rx_state_nxt = RX_IDLE;
            end else if (rx_bit_cnt == LAST_BIT) begin
               rx_state_nxt = RX_IDLE;
               rx_done      = 1'b1;
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // Receive datapath: mid-bit sampling, shift-in and response flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_cnt     <= '0;
         rx_bit_cnt <= '0;
         rx_shift   <= '0;
         resp       <= '0;
         resp_rdy   <= 1'b0;
      end else begin
         if (rx_start) begin
            rx_cnt     <= HALF_LAST;
            rx_bit_cnt <= '0;
         end else if (rx_sample) begin
            rx_cnt     <= BAUD_LAST;
            rx_bit_cnt <= rx_bit_cnt + BIT_W'(1);
            if ((rx_bit_cnt != '0) && (rx_bit_cnt != LAST_BIT))
               rx_shift <= {rx_sync, rx_shift[7:1]};
         end else if (rx_state == RX_BUSY) begin
            rx_cnt <= rx_cnt - CNT_W'(1);
         end
         // a completed byte beats a simultaneous clear
         if (rx_done) begin
            resp     <= rx_shift;
            resp_rdy <= 1'b1;
         end else if (clr_resp_rdy || rx_start) begin
            resp_rdy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: frame-level TX model checked every cycle,
// plus directed frame decoding and response-receive checks.
module tb_remote_comm;

   localparam int BD         = 240;     // reduced bit time keeps the run short
   localparam int M_FRAME    = 30 * BD;
   localparam int FRAME_CLKS = 7200;    // 30 bit times of 240 clocks

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic        TX;
   logic [7:0]  cmd = '0;
   logic [15:0] data = '0;
   logic        send_cmd = 1'b0;
   logic        cmd_sent;
   logic        resp_rdy;
   logic [7:0]  resp;
   logic        clr_resp_rdy = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   remote_comm #(.BAUD_DIV(BD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .RX           (RX),
      .TX           (TX),
      .cmd          (cmd),
      .data         (data),
      .send_cmd     (send_cmd),
      .cmd_sent     (cmd_sent),
      .resp_rdy     (resp_rdy),
      .resp         (resp),
      .clr_resp_rdy (clr_resp_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame model: an accepted request makes the line busy for 30 bit times
   logic        m_busy  = 1'b0;
   logic        m_sent  = 1'b0;
   int          m_t     = 0;
   logic [23:0] m_frame = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_sent <= 1'b0;
         m_t    <= 0;
      end else if (m_busy) begin
         if (m_t + 1 == M_FRAME) begin
            m_busy <= 1'b0;
            m_sent <= 1'b1;
         end
         m_t <= m_t + 1;
      end else if (send_cmd) begin
         m_busy  <= 1'b1;
         m_t     <= 0;
         m_frame <= {cmd, data};
         m_sent  <= 1'b0;
      end
   end

   // Line level t clocks into a frame: start 0, 8 data bits LSB first, stop 1
   function automatic logic exp_tx(input logic busy, input int t, input logic [23:0] fr);
      int bitn, byten, pos;
      logic [7:0] by;
      if (!busy) return 1'b1;
      bitn  = t / BD;
      byten = bitn / 10;
      pos   = bitn % 10;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      by = fr[23 - 8*byten -: 8];
      return by[pos-1];
   endfunction

   // Cycle-by-cycle comparison against the frame model
   always @(negedge clk) begin
      chk("tx_cycle", 32'(TX), 32'(exp_tx(m_busy, m_t, m_frame)));
      chk("cmd_sent_cycle", 32'(cmd_sent), 32'(m_sent));
   end

   task automatic pulse_send(input logic [7:0] c, input logic [15:0] d);
      @(posedge clk); #1;
      cmd = c; data = d; send_cmd = 1'b1;
      @(posedge clk); #1;
      send_cmd = 1'b0;
   endtask

   // Decode one frame from TX at mid-bit points and time cmd_sent
   task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2);
      logic [29:0] bits;
      int sent_at, ferr;
      bits    = '1;
      sent_at = -1;
      ferr    = 0;
      @(negedge clk);
      chk({name, "_start_bit"}, 32'(TX), 32'(0));
      chk({name, "_sent_low"}, 32'(cmd_sent), 32'(0));
      for (int k = 1; k <= FRAME_CLKS + 2; k++) begin
         @(negedge clk);
         if ((k % BD == BD / 2) && (k / BD < 30)) bits[k / BD] = TX;
         if (sent_at < 0 && cmd_sent === 1'b1) sent_at = k;
      end
      for (int i = 0; i < 3; i++) begin
         if (bits[10*i] !== 1'b0) ferr++;
         if (bits[10*i + 9] !== 1'b1) ferr++;
      end
      chk({name, "_byte0"}, 32'(bits[8:1]), 32'(e0));
      chk({name, "_byte1"}, 32'(bits[18:11]), 32'(e1));
      chk({name, "_byte2"}, 32'(bits[28:21]), 32'(e2));
      chk({name, "_framing"}, 32'(ferr), 32'(0));
      chk({name, "_sent_time"}, 32'(sent_at), 32'(FRAME_CLKS));
   endtask

   // Drive one 8N1 byte on RX; report resp_rdy just before the stop bit
   task automatic send_rx(input logic [7:0] b, output logic rdy_pre_stop);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      rdy_pre_stop = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         if (i == 9) rdy_pre_stop = resp_rdy;
         RX = fr[i];
         repeat (BD) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic pre, pre2, seen;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_tx", 32'(TX), 32'(1));
      chk("reset_cmd_sent", 32'(cmd_sent), 32'(0));
      chk("reset_resp_rdy", 32'(resp_rdy), 32'(0));
      chk("reset_resp", 32'(resp), 32'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // thrust frame
      pulse_send(8'h05, 16'h00FF);
      check_frame("thrust", 8'h05, 8'h00, 8'hFF);
      repeat (100) @(negedge clk);
      chk("thrust_sent_hold", 32'(cmd_sent), 32'(1));

      // roll frame with negative data
      pulse_send(8'h03, 16'hFF80);
      check_frame("roll", 8'h03, 8'hFF, 8'h80);

      // response receive and clear
      send_rx(8'hA5, pre);
      chk("rx_rdy_before_stop", 32'(pre), 32'(0));
      chk("rx_rdy", 32'(resp_rdy), 32'(1));
      chk("rx_resp", 32'(resp), 32'hA5);
      @(posedge clk); #1 clr_resp_rdy = 1'b1;
      @(posedge clk); #1 clr_resp_rdy = 1'b0;
      chk("clr_rdy", 32'(resp_rdy), 32'(0));
      chk("clr_resp_hold", 32'(resp), 32'hA5);

      // clear held through completion: the set must still be seen
      clr_resp_rdy = 1'b1;
      seen = 1'b0;
      fork
         send_rx(8'h3C, pre);
         begin
            for (int i = 0; i < 11 * BD; i++) begin
               @(negedge clk);
               if (resp_rdy === 1'b1) seen = 1'b1;
            end
         end
      join
      @(posedge clk); #1 clr_resp_rdy = 1'b0;
      chk("set_wins_over_clr", 32'(seen), 32'(1));
      chk("set_wins_resp", 32'(resp), 32'h3C);
      chk("set_wins_rdy_after", 32'(resp_rdy), 32'(0));

      // glitch rejection
      @(posedge clk); #1 RX = 1'b0;
      repeat (100) @(posedge clk);
      #1 RX = 1'b1;
      repeat (12 * BD) @(posedge clk);
      @(negedge clk);
      chk("glitch_rdy", 32'(resp_rdy), 32'(0));
      chk("glitch_resp", 32'(resp), 32'h3C);

      // a new start bit clears resp_rdy while resp holds
      send_rx(8'h81, pre);
      chk("rx81_rdy", 32'(resp_rdy), 32'(1));
      chk("rx81_resp", 32'(resp), 32'h81);
      fork
         send_rx(8'h00, pre);
         begin
            repeat (BD / 4) @(negedge clk);
            chk("start_clears_rdy", 32'(resp_rdy), 32'(0));
            chk("start_resp_hold", 32'(resp), 32'h81);
         end
      join
      chk("rx00_rdy", 32'(resp_rdy), 32'(1));
      chk("rx00_resp", 32'(resp), 32'h00);

      // busy frame: ignored request, input changes, concurrent receive
      pulse_send(8'h06, 16'h1234);
      fork
         check_frame("calib", 8'h06, 8'h12, 8'h34);
         begin
            repeat (500) @(posedge clk);
            #1 cmd = 8'h04; data = 16'h0080; send_cmd = 1'b1;
            @(posedge clk); #1 send_cmd = 1'b0;
            repeat (3000) @(posedge clk);
            #1 cmd = 8'h07; data = 16'hBEEF;
         end
         begin
            repeat (1000) @(posedge clk);
            send_rx(8'h5A, pre2);
         end
      join
      chk("rx_during_tx_resp", 32'(resp), 32'h5A);
      chk("rx_during_tx_rdy", 32'(resp_rdy), 32'(1));
      repeat (2 * BD) @(negedge clk);
      chk("no_second_frame_tx", 32'(TX), 32'(1));
      chk("no_second_frame_sent", 32'(cmd_sent), 32'(1));
      pulse_send(8'h04, 16'h0080);
      check_frame("yaw", 8'h04, 8'h00, 8'h80);

      // reset during the data[15:8] byte
      pulse_send(8'h07, 16'hABCD);
      repeat (15 * BD) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_tx", 32'(TX), 32'(1));
      chk("midrst_cmd_sent", 32'(cmd_sent), 32'(0));
      chk("midrst_resp_rdy", 32'(resp_rdy), 32'(0));
      chk("midrst_resp", 32'(resp), 32'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      pulse_send(8'h08, 16'h00C3);
      check_frame("mtrs_off", 8'h08, 8'h00, 8'hC3);

      repeat (10) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
